// File: rtl/gpr_wport_arb.sv
// gpr_wport_arb: arbitrates the single GPR write port between the WB stage and the md unit
// Ports:
//   i_clk, i_rst                   clock, async active-high reset
//   i_pipe_we/i_pipe_a3/i_pipe_wd  WB stage write request (priority, zero latency)
//   i_md_req/i_md_a3/i_md_wd       md unit result, held until o_md_ack
//   o_md_ack                       md result captured this cycle
//   o_pipe_stall                   freeze WB stage this cycle
//   o_gpr_we/o_gpr_a3/o_gpr_wd     to the GPR write port
//   o_md_pend/o_md_pend_a3         buffered md write outstanding, and its destination
//   o_force_cnt/o_waw_drop_cnt     perf counters, only with GPR_ARB_PERF_EN defined
module gpr_wport_arb #(
  parameter int MAX_WAIT = 4,
  parameter int AGE_W    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pipe_we,
  input  logic [4:0]  i_pipe_a3,
  input  logic [31:0] i_pipe_wd,
  input  logic        i_md_req,
  input  logic [4:0]  i_md_a3,
  input  logic [31:0] i_md_wd,
  output logic        o_md_ack,
  output logic        o_pipe_stall,
  output logic        o_gpr_we,
  output logic [4:0]  o_gpr_a3,
  output logic [31:0] o_gpr_wd,
  output logic        o_md_pend,
  output logic [4:0]  o_md_pend_a3
`ifdef GPR_ARB_PERF_EN
  ,
  output logic [31:0] o_force_cnt,
  output logic [31:0] o_waw_drop_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, HOLD, FORCE} state_t;
  state_t             r_state, w_state_nxt;
  logic [AGE_W-1:0]   r_age, w_age_nxt;
  logic [4:0]         r_buf_a3;
  logic [31:0]        r_buf_wd;
  logic               w_pend, w_pipe_wr, w_pipe_any, w_waw;
  assign w_pend     = r_state != IDLE;
  assign w_pipe_any = i_pipe_we && i_pipe_a3 != 5'd0;
  assign w_pipe_wr  = !o_pipe_stall && w_pipe_any;
  assign w_waw      = r_state == HOLD && w_pipe_any && i_pipe_a3 == r_buf_a3;
  // Outputs are forced low while reset is held so nothing reaches the GPR file.
  assign o_md_ack     = !i_rst && i_md_req && r_state == IDLE;
  assign o_pipe_stall = r_state == FORCE;
  assign o_gpr_we     = !i_rst && (w_pipe_wr || (w_pend && r_buf_a3 != 5'd0));
  assign o_gpr_a3     = i_rst ? 5'd0 : w_pipe_wr ? i_pipe_a3 : w_pend ? r_buf_a3 : 5'd0;
  assign o_gpr_wd     = i_rst ? 32'd0 : w_pipe_wr ? i_pipe_wd : w_pend ? r_buf_wd : 32'd0;
  assign o_md_pend    = w_pend;
  assign o_md_pend_a3 = w_pend ? r_buf_a3 : 5'd0;
  always_comb begin
    w_state_nxt = r_state;
    w_age_nxt   = '0;
    case (r_state)
      IDLE:  w_state_nxt = o_md_ack ? HOLD : IDLE;
      HOLD: begin
        if (!w_pipe_any || w_waw) begin
          w_state_nxt = IDLE;
        end else begin
          // Blocked by a younger pipe write to another register: age it.
          w_age_nxt   = r_age + AGE_W'(1);
          w_state_nxt = w_age_nxt == AGE_W'(MAX_WAIT) ? FORCE : HOLD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_age    <= '0;
      r_buf_a3 <= '0;
      r_buf_wd <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_age   <= w_age_nxt;
      if (o_md_ack) begin
        r_buf_a3 <= i_md_a3;
        r_buf_wd <= i_md_wd;
      end
    end
  end
`ifdef GPR_ARB_PERF_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_force_cnt    <= '0;
      o_waw_drop_cnt <= '0;
    end else begin
      if (o_pipe_stall && o_force_cnt != '1) o_force_cnt <= o_force_cnt + 32'd1;
      if (w_waw && o_waw_drop_cnt != '1) o_waw_drop_cnt <= o_waw_drop_cnt + 32'd1;
    end
  end
`endif
endmodule
